// File: rtl/mp_adder_seq.sv
// Control sequencer for the segmented carry-save multi-precision adder:
// Montgomery iterations, carry resolution, then bounded conditional subtraction.
module mp_adder_seq #(
  parameter int N_ITER   = 512,
  parameter int N_SEG    = 5,
  parameter int MAX_PASS = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       a_bit,
  input  logic       czero,
  input  logic       sub_done,
  output logic       enable_c,
  output logic       shift,
  output logic [3:0] seg,
  output logic       enable_carry,
  output logic       subtract,
  output logic [1:0] in_sel,
  output logic       a_adv,
  output logic       busy,
  output logic       done,
  output logic       overrun
);

  localparam int IW  = $clog2(N_ITER + 1);
  localparam int PWC = $clog2(MAX_PASS + 1);
  localparam int PW  = (PWC < 2) ? 2 : PWC;

  localparam logic [IW-1:0] ITER_LAST = IW'(N_ITER - 1);
  localparam logic [3:0]    SEG_LAST  = 4'(N_SEG - 1);
  localparam logic [PW-1:0] PASS_LAST = PW'(MAX_PASS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADD_B,
    S_ADD_M,
    S_SHIFT,
    S_RESOLVE,
    S_SUB,
    S_DONE
  } state_t;

  state_t        state;
  logic [IW-1:0] iter_cnt;
  logic [PW-1:0] pass_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      iter_cnt <= '0;
      pass_cnt <= '0;
      seg      <= '0;
      overrun  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state    <= S_ADD_B;
            iter_cnt <= '0;
            pass_cnt <= '0;
            seg      <= '0;
            overrun  <= 1'b0;
          end
        end
        S_ADD_B: state <= S_ADD_M;
        S_ADD_M: state <= S_SHIFT;
        S_SHIFT: begin
          iter_cnt <= iter_cnt + 1'b1;
          seg      <= '0;
          if (iter_cnt == ITER_LAST) state <= S_RESOLVE;
          else                       state <= S_ADD_B;
        end
        S_RESOLVE: begin
          if (seg == SEG_LAST) begin
            seg   <= '0;
            state <= S_SUB;
          end else begin
            seg <= seg + 1'b1;
          end
        end
        S_SUB: begin
          if (seg == SEG_LAST) begin
            // sub_done is only meaningful on the last segment of a pass
            seg      <= '0;
            pass_cnt <= pass_cnt + 1'b1;
            if (sub_done) begin
              state <= S_DONE;
            end else if (pass_cnt == PASS_LAST) begin
              state   <= S_DONE;
              overrun <= 1'b1;
            end
          end else begin
            seg <= seg + 1'b1;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Operand select follows a_bit/czero combinationally within the ADD cycles.
  always_comb begin
    enable_c     = 1'b0;
    shift        = 1'b0;
    enable_carry = 1'b0;
    subtract     = 1'b0;
    in_sel       = 2'd0;
    a_adv        = 1'b0;
    done         = 1'b0;
    case (state)
      S_ADD_B: begin
        enable_c = 1'b1;
        in_sel   = a_bit ? 2'd1 : 2'd0;
      end
      S_ADD_M: begin
        enable_c = 1'b1;
        in_sel   = czero ? 2'd2 : 2'd0;
      end
      S_SHIFT: begin
        shift = 1'b1;
        a_adv = 1'b1;
      end
      S_RESOLVE: enable_carry = 1'b1;
      S_SUB: begin
        enable_carry = 1'b1;
        subtract     = 1'b1;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_mp_adder_seq.sv
// Directed bench for mp_adder_seq with N_ITER=4, N_SEG=5, MAX_PASS=3.
module tb_mp_adder_seq;

  localparam int N_ITER   = 4;
  localparam int N_SEG    = 5;
  localparam int MAX_PASS = 3;

  logic       clk = 1'b0;
  logic       reset, start, a_bit, czero, sub_done;
  logic       enable_c, shift, enable_carry, subtract, a_adv, busy, done, overrun;
  logic [3:0] seg;
  logic [1:0] in_sel;

  int checks = 0;
  int passed = 0;

  mp_adder_seq #(.N_ITER(N_ITER), .N_SEG(N_SEG), .MAX_PASS(MAX_PASS)) dut (
    .clk(clk), .reset(reset), .start(start), .a_bit(a_bit), .czero(czero),
    .sub_done(sub_done), .enable_c(enable_c), .shift(shift), .seg(seg),
    .enable_carry(enable_carry), .subtract(subtract), .in_sel(in_sel),
    .a_adv(a_adv), .busy(busy), .done(done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  function automatic logic [13:0] outs();
    return {enable_c, shift, seg, enable_carry, subtract, in_sel, a_adv, busy, done, overrun};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts a run at the next edge (edge 0) and follows it cycle by cycle
  // against the expected schedule for a run ending in exp_done.
  task automatic run_op(input int tgt, input bit noisy, input int s1, input int s2,
                        input int exp_done, output int done_c, output int seq_err,
                        output int adv_cnt, output bit ov_done, output int ov_err);
    int         pass_seen;
    logic       e_ec, e_sh, e_adv, e_ecy, e_sub, e_done;
    logic [3:0] e_seg;
    logic [1:0] e_sel;
    done_c = -1; seq_err = 0; adv_cnt = 0; ov_done = 1'b0; ov_err = 0; pass_seen = 0;
    start = 1'b1; sub_done = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      e_ec = 0; e_sh = 0; e_adv = 0; e_ecy = 0; e_sub = 0; e_done = 0;
      e_seg = 4'd0; e_sel = 2'd0;
      if (c <= 3 * N_ITER) begin
        case ((c - 1) % 3)
          0: begin e_ec = 1; e_sel = a_bit ? 2'd1 : 2'd0; end
          1: begin e_ec = 1; e_sel = czero ? 2'd2 : 2'd0; end
          default: begin e_sh = 1; e_adv = 1; end
        endcase
      end else if (c <= 3 * N_ITER + N_SEG) begin
        e_ecy = 1; e_seg = 4'(c - 3 * N_ITER - 1);
      end else if (c < exp_done) begin
        e_ecy = 1; e_sub = 1; e_seg = 4'((c - 3 * N_ITER - N_SEG - 1) % N_SEG);
      end else begin
        e_done = 1;
      end
      if ({enable_c, shift, a_adv, enable_carry, subtract, seg, in_sel, done, busy} !==
          {e_ec, e_sh, e_adv, e_ecy, e_sub, e_seg, e_sel, e_done, 1'b1})
        seq_err++;
      if (a_adv === 1'b1) adv_cnt++;
      if (done === 1'b1) begin
        done_c  = c;
        ov_done = overrun;
        break;
      end
      if (overrun !== 1'b0) ov_err++;
      start = (c == s1) || (c == s2);
      if (subtract === 1'b1 && seg == 4'(N_SEG - 1)) begin
        pass_seen++;
        sub_done = (pass_seen == tgt);
      end else begin
        sub_done = noisy;
      end
      @(posedge clk); #1;
    end
    start = 1'b0; sub_done = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; a_bit = 1'b0; czero = 1'b0; sub_done = 1'b0;
    #2 reset = 1'b1;
    #1;
    checks++;
    if (outs() !== 14'd0) $display("FAIL reset_async: outputs %b required 0", outs());
    else passed++;
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    repeat (3) tick();
    checks++;
    if (outs() !== 14'd0) $display("FAIL reset_idle: outputs %b required 0", outs());
    else passed++;
  endtask

  task automatic test_basic();
    int dc, se, adv, oe; bit ov;
    a_bit = 1'b1; czero = 1'b1;
    run_op(1, 1'b0, 0, 0, 23, dc, se, adv, ov, oe);
    checks++; if (dc !== 23) $display("FAIL basic_latency: done cycle %0d required 23", dc); else passed++;
    checks++; if (se !== 0) $display("FAIL basic_sequence: %0d bad cycles required 0", se); else passed++;
    checks++; if (adv !== 4) $display("FAIL basic_a_adv: %0d pulses required 4", adv); else passed++;
    checks++; if (ov !== 1'b0) $display("FAIL basic_overrun: %0b required 0", ov); else passed++;
    tick();
    checks++; if (outs() !== 14'd0) $display("FAIL basic_after_done: outputs %b required 0", outs()); else passed++;
  endtask

  task automatic test_operand_zero();
    int dc, se, adv, oe; bit ov;
    a_bit = 1'b0; czero = 1'b0;
    run_op(1, 1'b0, 0, 0, 23, dc, se, adv, ov, oe);
    checks++; if (dc !== 23) $display("FAIL zero_latency: done cycle %0d required 23", dc); else passed++;
    checks++; if (se !== 0) $display("FAIL zero_in_sel: %0d bad cycles required 0", se); else passed++;
    tick();
  endtask

  task automatic test_two_passes();
    int dc, se, adv, oe; bit ov;
    a_bit = 1'b1; czero = 1'b0;
    run_op(2, 1'b1, 0, 0, 28, dc, se, adv, ov, oe);
    checks++; if (dc !== 28) $display("FAIL pass2_latency: done cycle %0d required 28", dc); else passed++;
    checks++; if (se !== 0) $display("FAIL pass2_sequence: %0d bad cycles required 0", se); else passed++;
    checks++; if (ov !== 1'b0) $display("FAIL pass2_overrun: %0b required 0", ov); else passed++;
    tick();
  endtask

  task automatic test_start_ignored();
    int dc, se, adv, oe; bit ov;
    a_bit = 1'b0; czero = 1'b1;
    run_op(1, 1'b0, 5, 20, 23, dc, se, adv, ov, oe);
    checks++; if (dc !== 23) $display("FAIL start_ignored_latency: done cycle %0d required 23", dc); else passed++;
    checks++; if (se !== 0) $display("FAIL start_ignored_sequence: %0d bad cycles required 0", se); else passed++;
    tick();
    checks++; if (busy !== 1'b0) $display("FAIL start_ignored_requeue: busy %0b required 0", busy); else passed++;
  endtask

  task automatic test_overrun_back_to_back();
    int dc, se, adv, oe; bit ov;
    a_bit = 1'b1; czero = 1'b1;
    run_op(0, 1'b0, 0, 0, 33, dc, se, adv, ov, oe);
    checks++; if (dc !== 33) $display("FAIL overrun_latency: done cycle %0d required 33", dc); else passed++;
    checks++; if (se !== 0) $display("FAIL overrun_sequence: %0d bad cycles required 0", se); else passed++;
    checks++; if (ov !== 1'b1) $display("FAIL overrun_flag: %0b required 1", ov); else passed++;
    tick();
    checks++;
    if ({busy, done, overrun} !== 3'b001) $display("FAIL overrun_hold: busy/done/overrun %b required 001", {busy, done, overrun});
    else passed++;
    run_op(1, 1'b0, 0, 0, 23, dc, se, adv, ov, oe);
    checks++; if (oe !== 0) $display("FAIL overrun_clear: %0d cycles with overrun set required 0", oe); else passed++;
    checks++; if (dc !== 23) $display("FAIL back_to_back_latency: done cycle %0d required 23", dc); else passed++;
    tick();
  endtask

  task automatic test_reset_mid();
    int dc, se, adv, oe, dones; bit ov;
    a_bit = 1'b1; czero = 1'b1; sub_done = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (14) tick();
    checks++;
    if ({enable_carry, subtract, seg} !== 6'b10_0010) $display("FAIL reset_mid_position: carry/sub/seg %b required 100010", {enable_carry, subtract, seg});
    else passed++;
    #2 reset = 1'b1;
    #1;
    checks++; if (outs() !== 14'd0) $display("FAIL reset_mid_outputs: %b required 0", outs()); else passed++;
    @(negedge clk);
    reset = 1'b0;
    dones = 0;
    repeat (10) begin
      tick();
      if (done === 1'b1) dones++;
    end
    checks++; if (dones !== 0) $display("FAIL reset_mid_no_done: %0d done pulses required 0", dones); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL reset_mid_idle: busy %0b required 0", busy); else passed++;
    run_op(1, 1'b0, 0, 0, 23, dc, se, adv, ov, oe);
    checks++; if (dc !== 23) $display("FAIL reset_mid_rerun: done cycle %0d required 23", dc); else passed++;
    checks++; if (se !== 0) $display("FAIL reset_mid_rerun_sequence: %0d bad cycles required 0", se); else passed++;
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_operand_zero();
    test_two_passes();
    test_start_ignored();
    test_overrun_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
